// File: rtl/spi_manchester_rx_if.sv
// spi_manchester_rx_if: link between the half-bit serial transmitter and
// the receiver.
//   in, en_in : serial data line and frame enable (driven by the transmitter)
//   data_out  : last completed word
//   valid     : one-cycle strobe when data_out updates
//   err       : one-cycle error strobe
//   err_code  : 01 symbol violation, 10 truncated frame
//   busy      : word partially received or receiver discarding after an error
// master = transmitter side, slave = receiver.
interface spi_manchester_rx_if #(
    parameter int DATA_W = 8
);
    logic              in;
    logic              en_in;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              err;
    logic [1:0]        err_code;
    logic              busy;

    modport master (
        output in, en_in,
        input  data_out, valid, err, err_code, busy
    );
    modport slave (
        input  in, en_in,
        output data_out, valid, err, err_code, busy
    );
endinterface

// File: rtl/spi_manchester_rx.sv
// spi_manchester_rx: decodes half-bit symbols (1 = high,low; 0 = low,high)
// into LSB-first DATA_W-bit words. Flags symbol violations and truncated frames.
//   clk : system clock, one half-bit per cycle
//   rst : asynchronous active-low reset
//   bus : spi_manchester_rx_if.slave (in/en_in in; data_out/valid/err/err_code/busy out)
module spi_manchester_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst,
    spi_manchester_rx_if.slave  bus
);
    localparam int             CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, HALF2, ERR} state_t;

    state_t             state, state_d;
    logic [SYNC_STAGES-1:0] d_sync, en_sync;
    logic               d_s, en_s;
    logic               h1, h1_d;
    logic [CW-1:0]      bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0]  shift, shift_d, data_q, data_d;
    logic               valid_q, valid_d, err_q, err_d;
    logic [1:0]         code_q, code_d;

    // Synchronizers on the pin inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_sync  <= '0;
            en_sync <= '0;
        end else begin
            d_sync  <= {d_sync[SYNC_STAGES-2:0], bus.in};
            en_sync <= {en_sync[SYNC_STAGES-2:0], bus.en_in};
        end
    end

    assign d_s  = d_sync[SYNC_STAGES-1];
    assign en_s = en_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            h1      <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state   <= state_d;
            h1      <= h1_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // shift is never cleared: every bit position is rewritten before a
    // word completes, so leftovers from an aborted frame cannot leak out.
    always_comb begin
        state_d   = state;
        h1_d      = h1;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        case (state)
            IDLE: begin
                if (en_s) begin
                    h1_d    = d_s;
                    state_d = HALF2;
                end else if (bit_cnt != '0) begin
                    err_d     = 1'b1;
                    code_d    = 2'b10;
                    bit_cnt_d = '0;
                end
            end
            HALF2: begin
                if (!en_s) begin
                    err_d     = 1'b1;
                    code_d    = 2'b10;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (h1 == d_s) begin
                    err_d     = 1'b1;
                    code_d    = 2'b01;
                    bit_cnt_d = '0;
                    state_d   = ERR;
                end else begin
                    // Legal pair: the first half carries the bit value.
                    shift_d[bit_cnt] = h1;
                    if (bit_cnt == LAST) begin
                        data_d    = shift_d;
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt + CW'(1);
                    end
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (!en_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.err      = err_q;
    assign bus.err_code = code_q;
    assign bus.busy     = (state != IDLE) || (bit_cnt != '0);
endmodule

// File: tb/tb_spi_manchester_rx.sv
module tb_spi_manchester_rx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_manchester_rx_if #(.DATA_W(8))  bus ();
    spi_manchester_rx_if #(.DATA_W(16)) bus2 ();

    spi_manchester_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    spi_manchester_rx #(.DATA_W(16), .SYNC_STAGES(3)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int cyc = 0;
    int hedge, hedge2;
    int vc[$], ec[$], vc2[$];
    logic [15:0] vd[$], vd2[$];
    int both = 0;
    int npass = 0, nchk = 0;
    int e1, e2, e3, ev, et;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs sampled mid-cycle; cyc then equals the edge that set them.
    always @(negedge clk) begin
        if (bus.valid) begin vc.push_back(cyc); vd.push_back(16'(bus.data_out)); end
        if (bus.err) ec.push_back(cyc);
        if (bus.valid && bus.err) both <= both + 1;
        if (bus2.valid) begin vc2.push_back(cyc); vd2.push_back(bus2.data_out); end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // One half-bit per call; hedge = edge that samples it.
    task automatic half(input logic b);
        @(negedge clk);
        bus.in = b; bus.en_in = 1'b1;
        hedge = cyc + 1;
    endtask
    task automatic sym(input logic b);
        half(b); half(~b);
    endtask
    task automatic word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) sym(w[i]);
    endtask
    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); bus.in = 1'b0; bus.en_in = 1'b0; end
    endtask
    task automatic half2(input logic b);
        @(negedge clk);
        bus2.in = b; bus2.en_in = 1'b1;
        hedge2 = cyc + 1;
    endtask

    task automatic clearq;
        vc.delete(); vd.delete(); ec.delete();
    endtask

    initial begin
        rst = 1'b0;
        bus.in = 1'b0; bus.en_in = 1'b0;
        bus2.in = 1'b0; bus2.en_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", bus.data_out, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_code", bus.err_code, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_data2", bus2.data_out, 0);
        rst = 1'b1;
        idle(3);

        // Single word 0xA5: valid two edges after the last half is sampled.
        word(8'hA5); e1 = hedge; idle(6);
        chk("a5_cnt", vc.size(), 1);
        chk("a5_data", vd[0], 16'hA5);
        chk("a5_edge", vc[0], e1 + 2);
        chk("a5_noerr", ec.size(), 0);
        chk("a5_busy", bus.busy, 0);

        // Back-to-back words with enable held high.
        clearq();
        word(8'h3C); e1 = hedge;
        word(8'hFF); e2 = hedge;
        chk("b2b_busy_mid", bus.busy, 1);
        word(8'h00); e3 = hedge;
        idle(6);
        chk("b2b_cnt", vc.size(), 3);
        chk("b2b_d0", vd[0], 16'h3C);
        chk("b2b_d1", vd[1], 16'hFF);
        chk("b2b_d2", vd[2], 16'h00);
        chk("b2b_edge0", vc[0], e1 + 2);
        chk("b2b_gap1", vc[1] - vc[0], 16);
        chk("b2b_gap2", vc[2] - vc[1], 16);
        chk("b2b_noerr", ec.size(), 0);
        chk("b2b_busy_end", bus.busy, 0);

        // Symbol violation: 11 pair at bit 3, frame continues afterwards.
        clearq();
        sym(1'b1); sym(1'b1); sym(1'b1);
        half(1'b1); half(1'b1); ev = hedge;
        repeat (4) sym(1'b0);
        chk("viol_busy", bus.busy, 1);
        chk("viol_errcnt", ec.size(), 1);
        chk("viol_edge", ec[0], ev + 2);
        chk("viol_code", bus.err_code, 2'b01);
        chk("viol_novalid", vc.size(), 0);
        idle(6);
        chk("viol_busy_after", bus.busy, 0);
        word(8'h0F); idle(6);
        chk("viol_next_cnt", vc.size(), 1);
        chk("viol_next_data", vd[0], 16'h0F);
        chk("viol_single_err", ec.size(), 1);

        // Truncated frame after 5 bits.
        clearq();
        sym(1'b1); sym(1'b0); sym(1'b1); sym(1'b1); sym(1'b0); et = hedge;
        idle(6);
        chk("trunc_errcnt", ec.size(), 1);
        chk("trunc_edge", ec[0], et + 3);
        chk("trunc_code", bus.err_code, 2'b10);
        chk("trunc_hold", bus.data_out, 8'h0F);
        chk("trunc_busy", bus.busy, 0);
        chk("trunc_novalid", vc.size(), 0);
        word(8'h81); idle(6);
        chk("trunc_next_cnt", vc.size(), 1);
        chk("trunc_next_data", vd[0], 16'h81);

        // Reset in the middle of a frame.
        clearq();
        repeat (4) sym(1'b1);
        #2 rst = 1'b0; bus.en_in = 1'b0;
        #1;
        chk("mrst_data", bus.data_out, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_code", bus.err_code, 0);
        chk("mrst_valid", bus.valid, 0);
        idle(3);
        rst = 1'b1;
        idle(3);
        chk("mrst_noerr", ec.size(), 0);
        word(8'h5A); idle(6);
        chk("mrst_next_cnt", vc.size(), 1);
        chk("mrst_next_data", vd[0], 16'h5A);
        chk("mrst_next_noerr", ec.size(), 0);

        // Wide word, three synchronizer stages.
        begin
            logic [15:0] w;
            w = 16'hBEEF;
            for (int i = 0; i < 16; i++) begin half2(w[i]); half2(~w[i]); end
        end
        repeat (8) begin @(negedge clk); bus2.in = 1'b0; bus2.en_in = 1'b0; end
        chk("w16_cnt", vc2.size(), 1);
        chk("w16_data", vd2[0], 16'hBEEF);
        chk("w16_edge", vc2[0], hedge2 + 3);
        chk("w16_busy", bus2.busy, 0);

        chk("never_valid_and_err", both, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
